// File: rtl/accelerator_fsm.sv
// Sequencer for one fully-connected layer: for every output neuron it walks all inputs,
// fetching the activation from BRAM and the weight from DRAM, then strobing the PE.
module accelerator_fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] DRAM_DATA,
    input  logic [15:0] BaseAddr_in,
    input  logic [15:0] total_input_neurons,
    input  logic [15:0] total_output_neurons,
    input  logic        DVAL,
    input  logic        accelerator_start,
    input  logic        Enable,
    output logic [15:0] Inaddress_current,
    output logic [15:0] Weight_data_current,
    output logic        neuron_done,
    output logic        add_done,
    output logic        Rd_BRAM_current,
    output logic        PE_enable,
    output logic        RD1_current,
    output logic [2:0]  state_dbg_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_MAC   = 3'd3,
        S_ADD   = 3'd4,
        S_NDONE = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] in_cnt_q, in_cnt_d;
    logic [15:0] out_cnt_q, out_cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] weight_q, weight_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            in_cnt_q  <= 16'h0000;
            out_cnt_q <= 16'h0000;
            addr_q    <= 16'h0000;
            weight_q  <= 16'h0000;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            addr_q    <= addr_d;
            weight_q  <= weight_d;
        end
    end

    // Enable low holds every register, so the whole machine freezes in place.
    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        addr_d    = addr_q;
        weight_d  = weight_q;
        if (Enable) begin
            case (state_q)
                S_IDLE: begin
                    if (accelerator_start && (total_input_neurons != 16'h0000)
                        && (total_output_neurons != 16'h0000)) begin
                        in_cnt_d  = 16'h0000;
                        out_cnt_d = 16'h0000;
                        addr_d    = BaseAddr_in;
                        state_d   = S_FETCH;
                    end
                end
                S_FETCH: state_d = S_WAIT;
                S_WAIT: begin
                    if (DVAL) begin
                        weight_d = DRAM_DATA;
                        state_d  = S_MAC;
                    end
                end
                S_MAC: state_d = S_ADD;
                S_ADD: begin
                    if (in_cnt_q == total_input_neurons - 16'd1) begin
                        state_d = S_NDONE;
                    end else begin
                        in_cnt_d = in_cnt_q + 16'd1;
                        addr_d   = addr_q + 16'd1;
                        state_d  = S_FETCH;
                    end
                end
                S_NDONE: begin
                    in_cnt_d = 16'h0000;
                    addr_d   = BaseAddr_in;
                    if (out_cnt_q == total_output_neurons - 16'd1) begin
                        state_d = S_IDLE;
                    end else begin
                        out_cnt_d = out_cnt_q + 16'd1;
                        state_d   = S_FETCH;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        Rd_BRAM_current = Enable && (state_q == S_FETCH);
        RD1_current     = Enable && ((state_q == S_FETCH) || (state_q == S_WAIT));
        PE_enable       = Enable && (state_q == S_MAC);
        add_done        = Enable && (state_q == S_ADD);
        neuron_done     = Enable && (state_q == S_NDONE);
    end

    assign Inaddress_current   = addr_q;
    assign Weight_data_current = weight_q;
    assign state_dbg_o         = state_q;

endmodule

// File: tb/tb_accelerator_fsm.sv
// Directed bench for accelerator_fsm: reset, single step, full layer, wrap,
// stall, zero-size start and mid-run reset, checked with immediate assertions.
module tb_accelerator_fsm;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_MAC   = 3'd3;
    localparam logic [2:0] ST_ADD   = 3'd4;
    localparam logic [2:0] ST_NDONE = 3'd5;

    logic        clk;
    logic        rst;
    logic [15:0] DRAM_DATA;
    logic [15:0] BaseAddr_in;
    logic [15:0] total_input_neurons;
    logic [15:0] total_output_neurons;
    logic        DVAL;
    logic        accelerator_start;
    logic        Enable;
    logic [15:0] Inaddress_current;
    logic [15:0] Weight_data_current;
    logic        neuron_done;
    logic        add_done;
    logic        Rd_BRAM_current;
    logic        PE_enable;
    logic        RD1_current;
    logic [2:0]  state_dbg_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_q[$];

    accelerator_fsm dut (
        .clk                  (clk),
        .rst                  (rst),
        .DRAM_DATA            (DRAM_DATA),
        .BaseAddr_in          (BaseAddr_in),
        .total_input_neurons  (total_input_neurons),
        .total_output_neurons (total_output_neurons),
        .DVAL                 (DVAL),
        .accelerator_start    (accelerator_start),
        .Enable               (Enable),
        .Inaddress_current    (Inaddress_current),
        .Weight_data_current  (Weight_data_current),
        .neuron_done          (neuron_done),
        .add_done             (add_done),
        .Rd_BRAM_current      (Rd_BRAM_current),
        .PE_enable            (PE_enable),
        .RD1_current          (RD1_current),
        .state_dbg_o          (state_dbg_o)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [4:0] strobes();
        return {Rd_BRAM_current, RD1_current, PE_enable, add_done, neuron_done};
    endfunction

    initial begin : stim
        int done1, done2, extra_done, pe_cnt, add_cnt;
        logic [15:0] exp_addr;

        // ---------------- reset with random inputs and start held
        rst = 1'b1;
        DRAM_DATA = 16'($urandom_range(0, 16'hFFFF));
        BaseAddr_in = 16'($urandom_range(0, 16'hFFFF));
        total_input_neurons = 16'($urandom_range(1, 16'hFFFF));
        total_output_neurons = 16'($urandom_range(1, 16'hFFFF));
        DVAL = 1'b1;
        accelerator_start = 1'b1;
        Enable = 1'b1;
        step();
        step();
        check("rst_state", state_dbg_o, ST_IDLE);
        check("rst_addr", Inaddress_current, 16'h0000);
        check("rst_weight", Weight_data_current, 16'h0000);
        check("rst_strobes", strobes(), 5'b00000);

        // ---------------- single step
        rst = 1'b0;
        BaseAddr_in = 16'h0000;
        total_input_neurons = 16'h0020;
        total_output_neurons = 16'h0010;
        DRAM_DATA = 16'h0011;
        DVAL = 1'b0;
        accelerator_start = 1'b1;
        step();
        accelerator_start = 1'b0;
        check("ss_fetch_state", state_dbg_o, ST_FETCH);
        check("ss_fetch_strobes", strobes(), 5'b11000);
        check("ss_fetch_addr", Inaddress_current, 16'h0000);
        step();
        check("ss_wait_strobes", strobes(), 5'b01000);
        step();
        check("ss_wait_hold_state", state_dbg_o, ST_WAIT);
        check("ss_wait_hold_strobes", strobes(), 5'b01000);
        DVAL = 1'b1;
        step();
        DVAL = 1'b0;
        check("ss_mac_state", state_dbg_o, ST_MAC);
        check("ss_mac_weight", Weight_data_current, 16'h0011);
        check("ss_mac_strobes", strobes(), 5'b00100);
        step();
        check("ss_add_strobes", strobes(), 5'b00010);
        step();
        check("ss_fetch2_addr", Inaddress_current, 16'h0001);
        check("ss_fetch2_strobes", strobes(), 5'b11000);
        step();
        check("ss_wait2_strobes", strobes(), 5'b01000);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("ss_reset_state", state_dbg_o, ST_IDLE);

        // ---------------- full layer N=3, M=2, DVAL held high
        BaseAddr_in = 16'h0100;
        total_input_neurons = 16'd3;
        total_output_neurons = 16'd2;
        DRAM_DATA = 16'h0abc;
        DVAL = 1'b1;
        for (int n = 0; n < 2; n++)
            for (int i = 0; i < 3; i++) exp_q.push_back(16'h0100 + 16'(i));
        done1 = -1; done2 = -1; extra_done = 0; pe_cnt = 0; add_cnt = 0;
        accelerator_start = 1'b1;
        step();
        accelerator_start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (PE_enable) begin
                pe_cnt++;
                if (exp_q.size() == 0) begin
                    check("fl_unexpected_pe", {16'h0, Inaddress_current}, 32'hFFFF_FFFF);
                end else begin
                    exp_addr = exp_q.pop_front();
                    check("fl_pe_addr", Inaddress_current, exp_addr);
                end
            end
            if (add_done) add_cnt++;
            if (neuron_done) begin
                if (done1 < 0) done1 = c;
                else if (done2 < 0) done2 = c;
                else extra_done++;
            end
            if (c == 14) check("fl_addr_rewind", Inaddress_current, 16'h0100);
            if (c == 27) check("fl_idle_after", state_dbg_o, ST_IDLE);
            step();
        end
        check("fl_done1_cycle", done1, 13);
        check("fl_done2_cycle", done2, 26);
        check("fl_extra_done", extra_done, 0);
        check("fl_pe_count", pe_cnt, 6);
        check("fl_add_count", add_cnt, 6);
        check("fl_queue_empty", exp_q.size(), 0);

        // ---------------- address wrap from 0xFFFF
        BaseAddr_in = 16'hFFFF;
        total_input_neurons = 16'd2;
        total_output_neurons = 16'd1;
        DRAM_DATA = 16'h1234;
        DVAL = 1'b1;
        accelerator_start = 1'b1;
        step();
        accelerator_start = 1'b0;
        check("wr_first_addr", Inaddress_current, 16'hFFFF);
        for (int c = 2; c <= 5; c++) step();
        check("wr_state5", state_dbg_o, ST_FETCH);
        check("wr_wrapped_addr", Inaddress_current, 16'h0000);
        for (int c = 6; c <= 9; c++) step();
        check("wr_ndone", strobes(), 5'b00001);
        step();
        check("wr_idle", state_dbg_o, ST_IDLE);

        // ---------------- stall in WAIT with DVAL high
        BaseAddr_in = 16'h0200;
        DVAL = 1'b0;
        accelerator_start = 1'b1;
        step();
        accelerator_start = 1'b0;
        step();
        check("st_in_wait", state_dbg_o, ST_WAIT);
        Enable = 1'b0;
        DVAL = 1'b1;
        DRAM_DATA = 16'hBEEF;
        for (int k = 0; k < 5; k++) begin
            step();
            check("st_frozen_state", state_dbg_o, ST_WAIT);
            check("st_strobes_off", strobes(), 5'b00000);
            check("st_weight_held", Weight_data_current, 16'h1234);
        end
        check("st_addr_held", Inaddress_current, 16'h0200);
        Enable = 1'b1;
        step();
        check("st_resume_state", state_dbg_o, ST_MAC);
        check("st_resume_weight", Weight_data_current, 16'hBEEF);
        check("st_resume_pe", strobes(), 5'b00100);
        step();
        check("st_resume_add", strobes(), 5'b00010);
        rst = 1'b1;
        step();
        rst = 1'b0;
        DVAL = 1'b0;

        // ---------------- zero-sized layer requests
        total_input_neurons = 16'd0;
        total_output_neurons = 16'd5;
        accelerator_start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("zn_state", state_dbg_o, ST_IDLE);
            check("zn_strobes", strobes(), 5'b00000);
        end
        total_input_neurons = 16'd5;
        total_output_neurons = 16'd0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("zm_state", state_dbg_o, ST_IDLE);
            check("zm_strobes", strobes(), 5'b00000);
        end
        accelerator_start = 1'b0;

        // ---------------- reset asserted in MAC
        BaseAddr_in = 16'h0300;
        total_input_neurons = 16'd4;
        total_output_neurons = 16'd1;
        DRAM_DATA = 16'h0055;
        DVAL = 1'b1;
        accelerator_start = 1'b1;
        step();
        accelerator_start = 1'b0;
        step();
        step();
        check("mr_in_mac", state_dbg_o, ST_MAC);
        check("mr_weight", Weight_data_current, 16'h0055);
        rst = 1'b1;
        step();
        check("mr_state", state_dbg_o, ST_IDLE);
        check("mr_addr", Inaddress_current, 16'h0000);
        check("mr_weight_clr", Weight_data_current, 16'h0000);
        check("mr_strobes", strobes(), 5'b00000);
        rst = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
